exec_alu: RTL and testbench
===========================

EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: synchronous, active-low reset, sampled on the clk_i rising edge.
REQ-004 The block SHALL have port valid_i, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port ALUCtrl_i, input, 4 bits: operation code produced by ALU_Control.
REQ-006 The block SHALL have port data1_i, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port data2_i, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-009 The block SHALL have port valid_o, output, 1 bit: a one-cycle pulse marking data_o/Zero_o as newly updated.
REQ-010 The block SHALL have port data_o, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port Zero_o, output, 1 bit: registered flag, high when data_o equals 0.
REQ-012 The block SHALL have port stall_o, output, 1 bit: pipeline-stall request, high while a multiply is in progress.

Function
REQ-013 A request SHALL be accepted on a rising edge where valid_i=1 and ready_o=1; operands and ALUCtrl_i SHALL be captured at that edge.
REQ-014 The block SHALL implement a two-state FSM: IDLE and MUL; ready_o SHALL be 1 exactly when the state is IDLE; stall_o SHALL equal NOT ready_o.
REQ-015 Single-cycle codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B).
REQ-016 For a single-cycle code accepted at edge N, data_o and Zero_o SHALL update and valid_o SHALL be 1 for the one cycle after edge N, with the state remaining IDLE.
REQ-017 Code 1111 (MUL) accepted at edge N SHALL enter MUL and compute the product by shift-add, one multiplier bit per cycle, using a log2(WIDTH)-bit counter.
REQ-018 The MUL result SHALL update at edge N+WIDTH; valid_o SHALL pulse for the following cycle; the state SHALL return to IDLE at that same edge.
REQ-019 MUL latency SHALL be fixed at WIDTH cycles regardless of operand values, with no early termination.
REQ-020 All arithmetic SHALL be unsigned modulo 2^WIDTH: ADD and SUB wrap, and MUL returns the low WIDTH bits of the product.
REQ-021 Any other ALUCtrl_i code SHALL complete as a single-cycle operation with data_o=0, Zero_o=1, and valid_o pulsing.
REQ-022 When valid_i=1 while ready_o=0, the request SHALL be ignored and no state SHALL change; the producer holds the request until it is accepted.
REQ-023 A new request SHALL be accepted at the edge where a MUL completes only if ready_o was 1 before that edge; since ready_o is 0 there, the earliest acceptance is edge N+WIDTH+1, the cycle in which valid_o is high.
REQ-024 Back-to-back single-cycle requests SHALL be accepted every cycle, with valid_o held high continuously.
REQ-025 data_o and Zero_o SHALL hold their values between completions; changes to data1_i/data2_i after acceptance SHALL have no effect.

Reset
REQ-026 When rst_i=0 at a rising edge, the state SHALL go to IDLE, the counter and internal registers SHALL clear, and data_o=0, Zero_o=1, valid_o=0 SHALL hold from the next cycle.
REQ-027 Reset during MUL SHALL abort the operation without producing a valid_o pulse; ready_o=1 and stall_o=0 SHALL hold in the cycle after the reset edge.
REQ-028 While rst_i=0, requests SHALL be ignored.

Verification
REQ-029 Bench scenario: ADD A=0x7FFFFFFF, B=1 -> one cycle later data_o=0x80000000, Zero_o=0, valid_o=1 for 1 cycle.
REQ-030 Bench scenario: SUB A=5, B=5, then AND 0xF0F0F0F0 with 0x0F0F0F0F on consecutive cycles -> data_o=0 with Zero_o=1 on both, valid_o high 2 consecutive cycles.
REQ-031 Bench scenario: MUL A=0xFFFFFFFF, B=2 -> ready_o=0 and stall_o=1 for 32 cycles; data_o=0xFFFFFFFE with valid_o pulsing at cycle 32.
REQ-032 Bench scenario: hold valid_i=1 with ADD during a MUL (A=3, B=7) -> ADD is ignored until ready_o=1; MUL result 21 appears, then the ADD completes one cycle after acceptance.
REQ-033 Bench scenario: rst_i=0 at cycle 10 of a MUL -> no valid_o pulse; next cycle ready_o=1, data_o=0, Zero_o=1.
REQ-034 Bench scenario: ALUCtrl_i=0101 with A=9, B=9 -> data_o=0, Zero_o=1, valid_o pulses once.

Source files
------------

// File: rtl/exec_alu.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB plus a multi-cycle shift-add
// multiply. Results and the zero flag are registered; valid_o pulses for one
// cycle whenever they are refreshed. stall_o holds the pipeline during MUL.
module exec_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             stall_o
);

  // Operation codes as produced by ALU_Control.
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpMul = 4'b1111;

  // Counter holds the index of the multiplier bit being consumed.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mul_a_q;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mul_b_q;   // multiplier, shifted right each step
  logic [WIDTH-1:0] acc_q;     // partial product, low WIDTH bits only

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;

  // Single-cycle result; unknown codes (MUL included, never used here) give 0.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OpAnd:   alu_res = data1_i & data2_i;
      OpOr:    alu_res = data1_i | data2_i;
      OpAdd:   alu_res = data1_i + data2_i;
      OpSub:   alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next = acc_q;
    if (mul_b_q[0]) begin
      acc_next = acc_q + mul_a_q;
    end
  end

  // FSM, multiply datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (ALUCtrl_i == OpMul) begin
              state_q <= StMul;
              mul_a_q <= data1_i;
              mul_b_q <= data2_i;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              data_o  <= alu_res;
              Zero_o  <= (alu_res == '0);
              valid_o <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q   <= acc_next;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
          // Fixed latency: always walk all WIDTH multiplier bits.
          if (cnt_q == CntLast) begin
            data_o  <= acc_next;
            Zero_o  <= (acc_next == '0);
            valid_o <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake decoded straight from the state register.
  always_comb begin
    ready_o = (state_q == StIdle);
    stall_o = ~ready_o;
  end

endmodule

// File: tb/tb_exec_alu.sv
// Directed bench for exec_alu with hand-computed expectations.
module tb_exec_alu;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        Zero_o;
  logic        stall_o;

  int n_tests;
  int n_fail;

  exec_alu #(
    .WIDTH(32)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .Zero_o   (Zero_o),
    .stall_o  (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  initial begin
    int bad;
    n_tests   = 0;
    n_fail    = 0;
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ALUCtrl_i = 4'h0;
    data1_i   = '0;
    data2_i   = '0;

    // Reset with a request present: request must be ignored.
    #2;
    req(4'b0010, 32'd1, 32'd1);
    tick();
    tick();
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_zero", {31'd0, Zero_o}, 32'd1);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    check("post_rst_valid", {31'd0, valid_o}, 32'd0);

    // ADD wraps into the sign bit.
    req(4'b0010, 32'h7FFF_FFFF, 32'd1);
    tick();
    valid_i = 1'b0;
    check("add_data", data_o, 32'h8000_0000);
    check("add_zero", {31'd0, Zero_o}, 32'd0);
    check("add_valid", {31'd0, valid_o}, 32'd1);
    data1_i = 32'h1234_5678;
    tick();
    check("add_valid_drop", {31'd0, valid_o}, 32'd0);
    check("add_hold", data_o, 32'h8000_0000);

    // SUB then AND back to back, both zero.
    req(4'b0110, 32'd5, 32'd5);
    tick();
    check("sub_data", data_o, 32'd0);
    check("sub_zero", {31'd0, Zero_o}, 32'd1);
    check("sub_valid", {31'd0, valid_o}, 32'd1);
    req(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    tick();
    valid_i = 1'b0;
    check("and_data", data_o, 32'd0);
    check("and_zero", {31'd0, Zero_o}, 32'd1);
    check("and_valid", {31'd0, valid_o}, 32'd1);
    tick();
    check("and_valid_drop", {31'd0, valid_o}, 32'd0);

    // OR and SUB underflow.
    req(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check("or_data", data_o, 32'h0000_00FF);
    req(4'b0110, 32'd0, 32'd1);
    tick();
    valid_i = 1'b0;
    check("sub_wrap", data_o, 32'hFFFF_FFFF);
    check("sub_wrap_zero", {31'd0, Zero_o}, 32'd0);

    // MUL 0xFFFFFFFF * 2: 32 busy cycles, low word of product.
    req(4'b0110, 32'd0, 32'd0);
    tick();
    req(4'b1111, 32'hFFFF_FFFF, 32'd2);
    tick();
    valid_i = 1'b0;
    data1_i = 32'd0;
    data2_i = 32'd0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (ready_o !== 1'b0 || stall_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'd0) bad++;
      tick();
    end
    check("mul1_busy_cycles", bad, 0);
    check("mul1_data", data_o, 32'hFFFF_FFFE);
    check("mul1_valid", {31'd0, valid_o}, 32'd1);
    check("mul1_ready", {31'd0, ready_o}, 32'd1);
    check("mul1_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("mul1_valid_drop", {31'd0, valid_o}, 32'd0);

    // MUL 3*7 with an ADD held pending throughout.
    req(4'b1111, 32'd3, 32'd7);
    tick();
    req(4'b0010, 32'd10, 32'd20);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (ready_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'hFFFF_FFFE) bad++;
      tick();
    end
    check("mul2_busy_cycles", bad, 0);
    check("mul2_data", data_o, 32'd21);
    check("mul2_valid", {31'd0, valid_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    check("held_add_data", data_o, 32'd30);
    check("held_add_valid", {31'd0, valid_o}, 32'd1);
    tick();
    check("held_add_drop", {31'd0, valid_o}, 32'd0);

    // MUL whose low word is zero.
    req(4'b1111, 32'h0001_0000, 32'h0001_0000);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    check("mul3_data", data_o, 32'd0);
    check("mul3_zero", {31'd0, Zero_o}, 32'd1);
    check("mul3_valid", {31'd0, valid_o}, 32'd1);

    // Reset in the middle of a MUL aborts it silently.
    req(4'b0010, 32'd15, 32'd15);
    tick();
    req(4'b1111, 32'd5, 32'd5);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check("abort_ready", {31'd0, ready_o}, 32'd1);
    check("abort_stall", {31'd0, stall_o}, 32'd0);
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_data", data_o, 32'd0);
    check("abort_zero", {31'd0, Zero_o}, 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0 || ready_o !== 1'b1) bad++;
      tick();
    end
    check("abort_quiet", bad, 0);

    // Undefined code 0101 yields zero.
    req(4'b0010, 32'd1, 32'd1);
    tick();
    check("pre_undef_data", data_o, 32'd2);
    req(4'b0101, 32'd9, 32'd9);
    tick();
    valid_i = 1'b0;
    check("undef_data", data_o, 32'd0);
    check("undef_zero", {31'd0, Zero_o}, 32'd1);
    check("undef_valid", {31'd0, valid_o}, 32'd1);
    tick();
    check("undef_valid_drop", {31'd0, valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
